// File: rtl/cnn_layer_accel_awe_output_merge_pkg.sv
// Shared types and width helpers for the AWE output merge block.
package cnn_layer_accel_awe_output_merge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRowCe0,
    StRowCe1,
    StDone
  } merge_state_e;

  localparam int unsigned DefPixelWidth = 16;
  localparam int unsigned DefNumCePerAwe = 2;
  localparam int unsigned DefFifoDepth = 64;

  function automatic int unsigned word_width(input int unsigned pixel_width,
                                             input int unsigned num_ce);
    return pixel_width * num_ce;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DefWordWidth = word_width(DefPixelWidth, DefNumCePerAwe);
  localparam int unsigned DefPtrWidth = ptr_width(DefFifoDepth);

endpackage

// File: rtl/cnn_layer_accel_awe_ce_fifo.sv
// Per-CE result FIFO: registered write, fall-through read, push accepted on full if popping.
module cnn_layer_accel_awe_ce_fifo
  import cnn_layer_accel_awe_output_merge_pkg::*;
#(
  parameter int unsigned Width = DefWordWidth,
  parameter int unsigned Depth = DefFifoDepth,
  localparam int unsigned PtrW = ptr_width(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cnn_layer_accel_awe_output_merge.sv
// Merges even-row (CE0) and odd-row (CE1) result streams into one raster-ordered tagged stream.
module cnn_layer_accel_awe_output_merge
  import cnn_layer_accel_awe_output_merge_pkg::*;
#(
  parameter int unsigned C_PIXEL_WIDTH = 16,
  parameter int unsigned C_NUM_CE_PER_AWE = 2,
  parameter int unsigned C_FIFO_DEPTH = 64,
  parameter int unsigned C_DIM_WIDTH = 10,
  localparam int unsigned W = word_width(C_PIXEL_WIDTH, C_NUM_CE_PER_AWE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [C_DIM_WIDTH-1:0] cfg_num_rows,
  input  logic [C_DIM_WIDTH-1:0] cfg_num_cols,
  input  logic [W-1:0]           ce0_pixel_dataout,
  input  logic                   ce0_pixel_dataout_valid,
  input  logic                   ce0_last_kernel,
  input  logic [W-1:0]           ce1_pixel_dataout,
  input  logic                   ce1_pixel_dataout_valid,
  input  logic                   ce1_last_kernel,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [C_DIM_WIDTH-1:0] out_row,
  output logic [C_DIM_WIDTH-1:0] out_col,
  output logic                   out_last_col,
  output logic                   out_last_map,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow_err
);

  localparam int unsigned CntW = ptr_width(C_FIFO_DEPTH) + 1;

  merge_state_e           state_q, state_d;
  logic [C_DIM_WIDTH-1:0] rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
  logic [C_DIM_WIDTH-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic [W-1:0]           out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d, out_last_col_q, out_last_col_d;
  logic                   out_last_map_q, out_last_map_d, ovf_q, ovf_d, ovf_clr;

  logic [W-1:0]    f0_data, f1_data, sel_data;
  logic [CntW-1:0] fifo0_count, fifo1_count;
  logic            f0_full, f1_full, f0_empty, f1_empty, f0_ovf, f1_ovf;
  logic            in_row, sel_empty, final_pending, load, last_col, last_row, pop0, pop1;
  logic            unused_fifo_status;

  assign unused_fifo_status = ^{fifo0_count, fifo1_count, f0_full, f1_full};

  cnn_layer_accel_awe_ce_fifo #(.Width(W), .Depth(C_FIFO_DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ce0_pixel_dataout_valid && ce0_last_kernel),
    .push_data (ce0_pixel_dataout),
    .pop       (pop0),
    .pop_data  (f0_data),
    .count     (fifo0_count),
    .full      (f0_full),
    .empty     (f0_empty),
    .overflow  (f0_ovf)
  );

  cnn_layer_accel_awe_ce_fifo #(.Width(W), .Depth(C_FIFO_DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ce1_pixel_dataout_valid && ce1_last_kernel),
    .push_data (ce1_pixel_dataout),
    .pop       (pop1),
    .pop_data  (f1_data),
    .count     (fifo1_count),
    .full      (f1_full),
    .empty     (f1_empty),
    .overflow  (f1_ovf)
  );

  assign in_row    = (state_q == StRowCe0) || (state_q == StRowCe1);
  assign sel_empty = (state_q == StRowCe1) ? f1_empty : f0_empty;
  assign sel_data  = (state_q == StRowCe1) ? f1_data : f0_data;
  assign last_col  = (col_q == cols_q - 1'b1);
  assign last_row  = (row_q == rows_q - 1'b1);
  // Once the final word sits in the output register, nothing more may load.
  assign final_pending = out_valid_q && out_last_map_q;
  assign load = in_row && (!out_valid_q || out_ready) && !sel_empty && !final_pending;
  assign pop0 = load && (state_q == StRowCe0);
  assign pop1 = load && (state_q == StRowCe1);

  // Counters and row toggle advance at load time so the next row's first word can
  // load in the same cycle the previous row's last word is accepted.
  always_comb begin
    state_d        = state_q;
    rows_d         = rows_q;
    cols_d         = cols_q;
    row_d          = row_q;
    col_d          = col_q;
    out_data_d     = out_data_q;
    out_row_d      = out_row_q;
    out_col_d      = out_col_q;
    out_last_col_d = out_last_col_q;
    out_last_map_d = out_last_map_q;
    out_valid_d    = out_valid_q && !out_ready;
    ovf_clr        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rows_d  = cfg_num_rows;
          cols_d  = cfg_num_cols;
          row_d   = '0;
          col_d   = '0;
          ovf_clr = 1'b1;
          state_d = StRowCe0;
        end
      end
      StRowCe0, StRowCe1: begin
        if (load) begin
          out_valid_d    = 1'b1;
          out_data_d     = sel_data;
          out_row_d      = row_q;
          out_col_d      = col_q;
          out_last_col_d = last_col;
          out_last_map_d = last_col && last_row;
          if (!last_col) begin
            col_d = col_q + 1'b1;
          end else if (!last_row) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = (state_q == StRowCe0) ? StRowCe1 : StRowCe0;
          end
        end
        if (final_pending && out_ready) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ovf_d = (ovf_clr ? 1'b0 : ovf_q) | f0_ovf | f1_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      rows_q         <= '0;
      cols_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      out_data_q     <= '0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      out_valid_q    <= 1'b0;
      out_last_col_q <= 1'b0;
      out_last_map_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rows_q         <= rows_d;
      cols_q         <= cols_d;
      row_q          <= row_d;
      col_q          <= col_d;
      out_data_q     <= out_data_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
      out_valid_q    <= out_valid_d;
      out_last_col_q <= out_last_col_d;
      out_last_map_q <= out_last_map_d;
      ovf_q          <= ovf_d;
    end
  end

  // busy drops as done rises, so the DONE state is excluded from busy.
  assign busy         = in_row;
  assign done         = (state_q == StDone);
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign out_last_col = out_last_col_q;
  assign out_last_map = out_last_map_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_cnn_layer_accel_awe_output_merge.sv
// Directed bench for the AWE output merge: ordering, tags, backpressure, overflow, reset.
module tb_cnn_layer_accel_awe_output_merge;

  localparam int unsigned PW = 16;
  localparam int unsigned NC = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW = 10;
  localparam int unsigned W = PW * NC;

  logic          clk, rst_n, start;
  logic [DW-1:0] cfg_num_rows, cfg_num_cols;
  logic [W-1:0]  ce0_data, ce1_data;
  logic          ce0_valid, ce1_valid, ce0_lk, ce1_lk;
  logic [W-1:0]  out_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_row, out_col;
  logic          out_last_col, out_last_map, busy, done, overflow_err;

  cnn_layer_accel_awe_output_merge #(
    .C_PIXEL_WIDTH   (PW),
    .C_NUM_CE_PER_AWE(NC),
    .C_FIFO_DEPTH    (DEPTH),
    .C_DIM_WIDTH     (DW)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .cfg_num_rows           (cfg_num_rows),
    .cfg_num_cols           (cfg_num_cols),
    .ce0_pixel_dataout      (ce0_data),
    .ce0_pixel_dataout_valid(ce0_valid),
    .ce0_last_kernel        (ce0_lk),
    .ce1_pixel_dataout      (ce1_data),
    .ce1_pixel_dataout_valid(ce1_valid),
    .ce1_last_kernel        (ce1_lk),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_row                (out_row),
    .out_col                (out_col),
    .out_last_col           (out_last_col),
    .out_last_map           (out_last_map),
    .busy                   (busy),
    .done                   (done),
    .overflow_err           (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic        toggle_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [31:0] d, input int r, input int c,
                                       input logic lc, input logic lm);
    return {10'd0, lm, lc, r[9:0], c[9:0], d};
  endfunction

  // Handshakes complete at the following posedge; inputs only change at posedge+1.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready)
        got_q.push_back(pack(out_data, out_row, out_col, out_last_col, out_last_map));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (toggle_ready) out_ready = ~out_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ce_word(input int ce, input logic [31:0] d, input logic lk);
    if (ce == 0) begin
      ce0_valid = 1'b1; ce0_data = d; ce0_lk = lk;
    end else begin
      ce1_valid = 1'b1; ce1_data = d; ce1_lk = lk;
    end
    tick();
    ce0_valid = 1'b0; ce1_valid = 1'b0; ce0_lk = 1'b0; ce1_lk = 1'b0;
  endtask

  task automatic start_map(input int rows, input int cols);
    got_q.delete();
    cfg_num_rows = rows[DW-1:0];
    cfg_num_cols = cols[DW-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk("done_seen", found, 1'b1);
    if (found) begin
      chk("busy_at_done", busy, 1'b0);
      @(negedge clk);
      chk("done_pulse_len", done, 1'b0);
    end
    tick();
  endtask

  task automatic check_words();
    chk("word_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("word", got_q[i], exp_q[i]);
  endtask

  // Row g comes from CE(g%2); CE0 words count up from 0, CE1 words from 0x100.
  task automatic run_map(input int rows, input int cols, input int gap);
    exp_q.delete();
    for (int g = 0; g < rows; g++)
      for (int c = 0; c < cols; c++)
        exp_q.push_back(pack(((g % 2) ? 32'h100 : 32'h0) + (g / 2) * cols + c, g, c,
                             c == cols - 1, (c == cols - 1) && (g == rows - 1)));
    start_map(rows, cols);
    for (int g = 0; g < rows; g++) begin
      for (int c = 0; c < cols; c++)
        ce_word(g % 2, ((g % 2) ? 32'h100 : 32'h0) + (g / 2) * cols + c, 1'b1);
      repeat (gap) tick();
    end
    wait_done(400);
    check_words();
    chk("no_overflow", overflow_err, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_num_rows = '0; cfg_num_cols = '0;
    ce0_data = '0; ce1_data = '0; ce0_valid = 1'b0; ce1_valid = 1'b0;
    ce0_lk = 1'b0; ce1_lk = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow_err, 1'b0);
    chk("rst_last_map", out_last_map, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic 4x3 map at full throughput.
    run_map(4, 3, 0);

    // Same map under alternating backpressure.
    toggle_ready = 1'b1;
    run_map(4, 3, 4);
    toggle_ready = 1'b0;
    tick();
    out_ready = 1'b1;

    // Only last_kernel words are captured; data arriving in IDLE is kept.
    for (int i = 0; i < 5; i++) ce_word(0, 32'hdead_0000 + i, 1'b0);
    for (int i = 0; i < 3; i++) ce_word(0, 32'h10 + i, 1'b1);
    chk("lk_fifo0_count", dut.fifo0_count, 3);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(pack(32'h10 + i, 0, i, i == 2, i == 2));
    start_map(1, 3);
    wait_done(100);
    check_words();

    // Overflow on a full FIFO, cleared by the next start.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) ce_word(0, 32'h20 + i, 1'b1);
    chk("ovf_before", overflow_err, 1'b0);
    ce_word(0, 32'h24, 1'b1);
    chk("ovf_set", overflow_err, 1'b1);
    chk("ovf_fifo0_count", dut.fifo0_count, 4);
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(pack(32'h20 + i, 0, i, i == 3, i == 3));
    start_map(1, 4);
    chk("ovf_cleared", overflow_err, 1'b0);
    wait_done(100);
    check_words();

    // CE1 data early: output must still start with CE0 row 0.
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(pack(32'h300 + i, 0, i, i == 2, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(pack(32'h200 + i, 1, i, i == 2, i == 2));
    start_map(2, 3);
    for (int i = 0; i < 3; i++) ce_word(1, 32'h200 + i, 1'b1);
    repeat (7) tick();
    chk("early_ce1_no_out", out_valid, 1'b0);
    chk("early_ce1_count", dut.fifo1_count, 3);
    for (int i = 0; i < 3; i++) ce_word(0, 32'h300 + i, 1'b1);
    wait_done(100);
    check_words();

    // Asynchronous reset mid-row.
    out_ready = 1'b0;
    start_map(2, 4);
    ce_word(0, 32'h40, 1'b1);
    ce_word(0, 32'h41, 1'b1);
    ce_word(1, 32'h50, 1'b1);
    ce_word(1, 32'h51, 1'b1);
    chk("midrow_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 32'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_fifo0", dut.fifo0_count, 0);
    chk("arst_fifo1", dut.fifo1_count, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_fifo1", dut.fifo1_count, 0);
    run_map(4, 3, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
